// File: rtl/seg7_to_signed.sv
// Active-low 7-segment digit stream (MSD first) -> signed WIDTH-bit word on a valid/ready port.
// Optional macro SEG7_BLANK_LEADING_EN: blank pattern 0x7F accepted as a leading zero.
module seg7_to_signed #(
    parameter int WIDTH = 11,
    parameter int NDIG  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    input  logic             seg_last,
    input  logic             neg_in,
    output logic             seg_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_invalid,
    output logic             err_overflow,
    output logic [1:0]       state_dbg
);
    localparam int AW = WIDTH + 4;
    localparam int PW = AW + 4;
    localparam int CW = $clog2(NDIG + 2);
    localparam logic [AW-1:0]    ACC_CLAMP = AW'(2 ** WIDTH);
    localparam logic [AW-1:0]    LIM_POS   = AW'(2 ** (WIDTH - 1) - 1);
    localparam logic [AW-1:0]    LIM_NEG   = AW'(2 ** (WIDTH - 1));
    localparam logic [WIDTH-1:0] SAT_POS   = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG   = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [CW-1:0]    CNT_MAX   = CW'(NDIG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Handshakes: a digit transfers on a rising edge where seg_valid && seg_ready;
    // a result transfers on a rising edge where out_valid && out_ready, and
    // data_out/err_* hold steady while out_valid && !out_ready.
    state_t           state_q;
    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             inv_q;
    logic             cnt_ovf_q;
    logic             seg_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] data_q;
    logic             err_inv_q;
    logic             err_ovf_q;

    logic [3:0]       digit;
    logic             legal;
    logic             blank;
    logic             accept;
    logic [PW-1:0]    sum_d;
    logic [AW-1:0]    acc_d;
    logic [CW-1:0]    cnt_d;
    logic             inv_d;
    logic             cnt_ovf_d;
    logic [AW-1:0]    limit;
    logic             mag_ovf;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] result_d;

    assign accept    = seg_valid && seg_ready_q;
    assign seg_ready = seg_ready_q;
    assign data_out  = data_q;
    assign out_valid = out_valid_q;
    assign err_invalid  = err_inv_q;
    assign err_overflow = err_ovf_q;
    assign state_dbg = state_q;

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (seg_in)
            7'h40: digit = 4'd0;
            7'h79: digit = 4'd1;
            7'h24: digit = 4'd2;
            7'h30: digit = 4'd3;
            7'h19: digit = 4'd4;
            7'h12: digit = 4'd5;
            7'h02: digit = 4'd6;
            7'h78: digit = 4'd7;
            7'h00: digit = 4'd8;
            7'h10: digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

`ifdef SEG7_BLANK_LEADING_EN
    logic seen_nz_q;
    assign blank = (seg_in == 7'h7F) && !seen_nz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_nz_q <= 1'b0;
        end else if (state_q == DONE) begin
            seen_nz_q <= 1'b0;
        end else if (accept && legal && digit != 4'd0) begin
            seen_nz_q <= 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        sum_d = PW'(acc_q) * PW'(10) + PW'(digit);
        // Clamp just above any legal magnitude so long inputs never wrap back into range.
        if (sum_d > PW'(ACC_CLAMP)) begin
            acc_d = ACC_CLAMP;
        end else begin
            acc_d = sum_d[AW-1:0];
        end
        cnt_d     = (cnt_q > CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cnt_ovf_d = cnt_ovf_q | (cnt_q >= CNT_MAX);
        inv_d     = inv_q | !legal;
        if (blank) begin
            acc_d     = acc_q;
            cnt_d     = cnt_q;
            cnt_ovf_d = cnt_ovf_q;
            inv_d     = inv_q;
        end
        limit   = neg_in ? LIM_NEG : LIM_POS;
        mag_ovf = acc_d > limit;
        mag     = acc_d[WIDTH-1:0];
        // Only an out-of-range magnitude saturates; a digit-count overflow
        // (e.g. extra leading zeros) flags the error but keeps the in-range value.
        if (mag_ovf) begin
            result_d = neg_in ? SAT_NEG : SAT_POS;
        end else if (neg_in) begin
            result_d = -mag;
        end else begin
            result_d = mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            cnt_ovf_q   <= 1'b0;
            seg_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            err_inv_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    seg_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q     <= acc_d;
                        cnt_q     <= cnt_d;
                        inv_q     <= inv_d;
                        cnt_ovf_q <= cnt_ovf_d;
                        if (seg_last) begin
                            state_q     <= DONE;
                            seg_ready_q <= 1'b0;
                            out_valid_q <= 1'b1;
                            data_q      <= result_d;
                            err_inv_q   <= inv_d;
                            err_ovf_q   <= cnt_ovf_d | mag_ovf;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        seg_ready_q <= 1'b1;
                        out_valid_q <= 1'b0;
                        err_inv_q   <= 1'b0;
                        err_ovf_q   <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        inv_q       <= 1'b0;
                        cnt_ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    seg_ready_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
